// File: rtl/i2c_resp_pkg.sv
// Shared types and constants for the WM8731-style I2C control-port responder.
package i2c_resp_pkg;

   localparam int unsigned NUM_REGS  = 10;
   localparam logic [6:0]  RESET_REG = 7'h0F;

   // Packed with R9 in the top slot so REG_DEFAULTS[n] is the default of Rn.
   localparam logic [NUM_REGS-1:0][8:0] REG_DEFAULTS = {
      9'h000, 9'h000, 9'h00A, 9'h09F, 9'h008,
      9'h00A, 9'h079, 9'h079, 9'h097, 9'h097
   };

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_DEV_ADDR = 3'd1,
      ST_DEV_ACK  = 3'd2,
      ST_BYTE_HI  = 3'd3,
      ST_ACK_HI   = 3'd4,
      ST_BYTE_LO  = 3'd5,
      ST_ACK_LO   = 3'd6,
      ST_IGNORE   = 3'd7
   } state_t;

   typedef struct packed {
      logic [6:0] addr;
      logic [8:0] data;
   } reg_word_t;

   function automatic logic is_write_to(input logic [7:0] addr_byte, input logic [6:0] dev);
      return addr_byte == {dev, 1'b0};
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Synchronizer, optional debounce filter (I2C_RESP_FILTER_EN) and edge pulses for one I2C line.
module i2c_line_sync #(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_line,
   output logic o_level,
   output logic o_rise,
   output logic o_fall
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   level;
   logic                   prev_q;

   // Idle I2C lines are high, so reset to 1 to avoid a spurious edge after reset.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         sync_q <= '1;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], i_line};
      end
   end

   assign synced = sync_q[SYNC_STAGES-1];

`ifdef I2C_RESP_FILTER_EN
   localparam int unsigned CW = $clog2(FILTER_LEN + 1);

   logic [CW-1:0] cnt_q;
   logic          level_q;

   // Counts consecutive samples that disagree with the accepted level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         cnt_q   <= '0;
         level_q <= 1'b1;
      end else if (synced == level_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
         cnt_q   <= '0;
         level_q <= synced;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign level = level_q;
`else
   assign level = synced;
`endif

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= level;
      end
   end

   assign o_level = level;
   assign o_rise  = level & ~prev_q;
   assign o_fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_codec_responder.sv
// WM8731 control-port I2C target: decodes 3-byte writes, ACKs them and keeps a 10x9 register file.
// Optional input debouncing is enabled with I2C_RESP_FILTER_EN.
module i2c_codec_responder
   import i2c_resp_pkg::*;
#(
   parameter logic [6:0]  DEV_ADDR    = 7'h1A,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned FILTER_LEN  = 4
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_scl,
   input  logic       i_sda,
   output logic       o_sda_oe,
   output logic       o_wr_valid,
   output logic [6:0] o_wr_addr,
   output logic [8:0] o_wr_data,
   output logic       o_addr_nack,
   output logic       o_busy,
   input  logic [3:0] i_reg_sel,
   output logic [8:0] o_reg_data
);

   logic scl_level, scl_rise, scl_fall;
   logic sda_level, sda_rise, sda_fall;
   logic start_cond, stop_cond;

   state_t                    state_q;
   logic [3:0]                bit_cnt_q;
   logic [7:0]                shift_q;
   logic [7:0]                hi_q;
   logic                      sda_oe_q;
   logic                      busy_q;
   logic                      wr_valid_q;
   logic                      nack_q;
   reg_word_t                 wr_word_q;
   logic [NUM_REGS-1:0][8:0]  regs_q;

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_scl_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_line  (i_scl),
      .o_level (scl_level),
      .o_rise  (scl_rise),
      .o_fall  (scl_fall)
   );

   i2c_line_sync #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_sda_sync (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_line  (i_sda),
      .o_level (sda_level),
      .o_rise  (sda_rise),
      .o_fall  (sda_fall)
   );

   assign start_cond = sda_fall & scl_level;
   assign stop_cond  = sda_rise & scl_level;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         hi_q       <= '0;
         sda_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         wr_valid_q <= 1'b0;
         nack_q     <= 1'b0;
         wr_word_q  <= '0;
      end else begin
         wr_valid_q <= 1'b0;
         nack_q     <= 1'b0;
         if (start_cond) begin
            state_q   <= ST_DEV_ADDR;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b1;
         end else if (stop_cond) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
         end else begin
            case (state_q)
               ST_DEV_ADDR, ST_BYTE_HI, ST_BYTE_LO: begin
                  if (scl_rise && bit_cnt_q != 4'd8) begin
                     shift_q   <= {shift_q[6:0], sda_level};
                     bit_cnt_q <= bit_cnt_q + 4'd1;
                  end else if (scl_fall && bit_cnt_q == 4'd8) begin
                     // Falling edge after the 8th bit: enter the ACK clock.
                     bit_cnt_q <= '0;
                     if (state_q == ST_DEV_ADDR) begin
                        if (is_write_to(shift_q, DEV_ADDR)) begin
                           state_q  <= ST_DEV_ACK;
                           sda_oe_q <= 1'b1;
                        end else begin
                           state_q <= ST_IGNORE;
                           nack_q  <= 1'b1;
                        end
                     end else if (state_q == ST_BYTE_HI) begin
                        hi_q     <= shift_q;
                        state_q  <= ST_ACK_HI;
                        sda_oe_q <= 1'b1;
                     end else begin
                        state_q  <= ST_ACK_LO;
                        sda_oe_q <= 1'b1;
                     end
                  end
               end
               ST_DEV_ACK, ST_ACK_HI, ST_ACK_LO: begin
                  if (scl_fall) begin
                     sda_oe_q <= 1'b0;
                     if (state_q == ST_DEV_ACK) begin
                        state_q <= ST_BYTE_HI;
                     end else if (state_q == ST_ACK_HI) begin
                        state_q <= ST_BYTE_LO;
                     end else begin
                        state_q        <= ST_IGNORE;
                        wr_valid_q     <= 1'b1;
                        wr_word_q.addr <= hi_q[7:1];
                        wr_word_q.data <= {hi_q[0], shift_q};
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // The register file updates from the committed word, one cycle behind o_wr_valid.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         regs_q <= REG_DEFAULTS;
      end else if (wr_valid_q) begin
         if (wr_word_q.addr < 7'(NUM_REGS)) begin
            regs_q[wr_word_q.addr[3:0]] <= wr_word_q.data;
         end else if (wr_word_q.addr == RESET_REG) begin
            regs_q <= REG_DEFAULTS;
         end
      end
   end

   always_comb begin
      o_reg_data = 9'h000;
      if (i_reg_sel < 4'(NUM_REGS)) begin
         o_reg_data = regs_q[i_reg_sel];
      end
   end

   assign o_sda_oe    = sda_oe_q;
   assign o_wr_valid  = wr_valid_q;
   assign o_wr_addr   = wr_word_q.addr;
   assign o_wr_data   = wr_word_q.data;
   assign o_addr_nack = nack_q;
   assign o_busy      = busy_q;

endmodule

// File: tb/tb_i2c_codec_responder.sv
// Self-checking bench for i2c_codec_responder: directed tables plus randomized writes vs a model.
module tb_i2c_codec_responder;

   localparam int Q = 10;  // clk cycles per quarter SCL bit

   logic       clk = 1'b0;
   logic       rst;
   logic       scl_drv;
   logic       sda_drv;
   logic       sda_bus;
   logic       sda_oe;
   logic       wr_valid;
   logic [6:0] wr_addr;
   logic [8:0] wr_data;
   logic       addr_nack;
   logic       busy;
   logic [3:0] reg_sel;
   logic [8:0] reg_data;

   int checks = 0;
   int errors = 0;

   assign sda_bus = sda_drv & ~sda_oe;

   always #5 clk = ~clk;

   i2c_codec_responder dut (
      .i_clk       (clk),
      .i_rst       (rst),
      .i_scl       (scl_drv),
      .i_sda       (sda_bus),
      .o_sda_oe    (sda_oe),
      .o_wr_valid  (wr_valid),
      .o_wr_addr   (wr_addr),
      .o_wr_data   (wr_data),
      .o_addr_nack (addr_nack),
      .o_busy      (busy),
      .i_reg_sel   (reg_sel),
      .o_reg_data  (reg_data)
   );

   // Bus monitor
   logic [15:0] commits[$];
   int          nack_cnt = 0;
   bit          oe_seen = 1'b0;
   bit          busy_seen = 1'b0;

   always @(posedge clk) begin
      if (wr_valid) commits.push_back({wr_addr, wr_data});
      if (addr_nack) nack_cnt <= nack_cnt + 1;
      if (sda_oe) oe_seen <= 1'b1;
      if (busy) busy_seen <= 1'b1;
   end

   // Reference register file
   logic [8:0] mregs[10];

   function automatic logic [8:0] reg_default(input int n);
      case (n)
         0, 1:    return 9'h097;
         2, 3:    return 9'h079;
         4, 7:    return 9'h00A;
         5:       return 9'h008;
         6:       return 9'h09F;
         default: return 9'h000;
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 10; i++) mregs[i] = reg_default(i);
   endtask

   task automatic model_write(input int a, input logic [8:0] d);
      if (a < 10) mregs[a] = d;
      else if (a == 15) model_reset();
   endtask

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic i2c_start();
      sda_drv = 1'b1; cyc(Q);
      scl_drv = 1'b1; cyc(Q);
      sda_drv = 1'b0; cyc(Q);
      scl_drv = 1'b0; cyc(Q);
   endtask

   task automatic i2c_stop();
      sda_drv = 1'b0; cyc(Q);
      scl_drv = 1'b1; cyc(Q);
      sda_drv = 1'b1; cyc(Q);
   endtask

   task automatic i2c_byte(input logic [7:0] b, output bit ack);
      for (int i = 7; i >= 0; i--) begin
         sda_drv = b[i]; cyc(Q);
         scl_drv = 1'b1; cyc(2 * Q);
         scl_drv = 1'b0; cyc(Q);
      end
      sda_drv = 1'b1; cyc(Q);
      scl_drv = 1'b1; cyc(Q);
      ack = ~sda_bus;
      cyc(Q);
      scl_drv = 1'b0; cyc(Q);
   endtask

   task automatic clear_mon();
      commits.delete();
      nack_cnt  = 0;
      oe_seen   = 1'b0;
      busy_seen = 1'b0;
   endtask

   task automatic chk_regs(input string tag);
      for (int s = 0; s < 16; s++) begin
         reg_sel = 4'(s);
         #1;
         chk($sformatf("%s reg[%0d]", tag, s), int'(reg_data), (s < 10) ? int'(mregs[s]) : 0);
      end
   endtask

   // Full write transaction of n bytes followed by STOP; expectations come from the I2C rules.
   task automatic txn(input string tag, input logic [31:0] bytes, input int n);
      logic [7:0] b0, b1, b2, cur;
      bit         ack, dev_ok;
      int         exp_commits;
      logic [15:0] got;
      b0 = bytes[31:24];
      b1 = bytes[23:16];
      b2 = bytes[15:8];
      dev_ok = (b0 == 8'h34);
      clear_mon();
      i2c_start();
      chk({tag, " busy after START"}, int'(busy), 1);
      for (int i = 0; i < n; i++) begin
         cur = bytes[31 - 8 * i -: 8];
         i2c_byte(cur, ack);
         chk($sformatf("%s ack byte%0d", tag, i), int'(ack),
             (i == 0) ? int'(dev_ok) : int'(dev_ok && i < 3));
      end
      i2c_stop();
      cyc(Q);
      chk({tag, " busy after STOP"}, int'(busy), 0);
      chk({tag, " nack pulses"}, nack_cnt, dev_ok ? 0 : 1);
      exp_commits = (dev_ok && n >= 3) ? 1 : 0;
      chk({tag, " commit count"}, commits.size(), exp_commits);
      if (exp_commits == 1) begin
         model_write(int'(b1[7:1]), {b1[0], b2});
         if (commits.size() > 0) begin
            got = commits.pop_front();
            chk({tag, " commit word"}, int'(got), int'({b1[7:1], b1[0], b2}));
         end
      end
      chk_regs(tag);
   endtask

   typedef struct {
      logic [3:0] sel;
      logic [8:0] exp;
   } rd_vec_t;

   rd_vec_t rd_vec[11];

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not reach its end, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] got;
      bit          ack;
      logic [7:0]  rb0, rb1, rb2, rb3;
      int          rn;

      rd_vec = '{
         '{4'd0, 9'h097}, '{4'd1, 9'h097}, '{4'd2, 9'h079}, '{4'd3, 9'h079},
         '{4'd4, 9'h00A}, '{4'd5, 9'h008}, '{4'd6, 9'h09F}, '{4'd7, 9'h00A},
         '{4'd8, 9'h000}, '{4'd9, 9'h000}, '{4'd12, 9'h000}
      };

      rst = 1'b1; scl_drv = 1'b1; sda_drv = 1'b1; reg_sel = 4'd0;
      model_reset();
      cyc(5);
      chk("reset sda_oe", int'(sda_oe), 0);
      chk("reset wr_valid", int'(wr_valid), 0);
      chk("reset wr_addr", int'(wr_addr), 0);
      chk("reset wr_data", int'(wr_data), 0);
      chk("reset addr_nack", int'(addr_nack), 0);
      chk("reset busy", int'(busy), 0);
      rst = 1'b0;
      cyc(5);

      for (int i = 0; i < 11; i++) begin
         reg_sel = rd_vec[i].sel;
         #1;
         chk($sformatf("default sel %0d", rd_vec[i].sel), int'(reg_data), int'(rd_vec[i].exp));
      end

      txn("w04", 32'h34081500, 3);
      reg_sel = 4'd4; #1;
      chk("reg4 literal", int'(reg_data), 9'h015);
      txn("w09", 32'h34120100, 3);
      reg_sel = 4'd9; #1;
      chk("reg9 literal", int'(reg_data), 9'h001);
      txn("wrst", 32'h341E0000, 3);
      reg_sel = 4'd4; #1;
      chk("reg4 after reset reg", int'(reg_data), 9'h00A);
      reg_sel = 4'd9; #1;
      chk("reg9 after reset reg", int'(reg_data), 9'h000);

      // Wrong address and read bit must never be acknowledged.
      clear_mon();
      txn("addr36", 32'h36081500, 2);
      chk("addr36 no sda pull", int'(oe_seen), 0);
      clear_mon();
      txn("addr35", 32'h35081500, 2);
      chk("addr35 no sda pull", int'(oe_seen), 0);

      // Repeated START discards the partial word.
      clear_mon();
      i2c_start();
      i2c_byte(8'h34, ack); chk("rs ack0", int'(ack), 1);
      i2c_byte(8'h08, ack); chk("rs ack1", int'(ack), 1);
      i2c_start();
      chk("rs busy", int'(busy), 1);
      i2c_byte(8'h34, ack); chk("rs ack2", int'(ack), 1);
      i2c_byte(8'h0C, ack); chk("rs ack3", int'(ack), 1);
      i2c_byte(8'h1F, ack); chk("rs ack4", int'(ack), 1);
      i2c_stop();
      cyc(Q);
      chk("rs commit count", commits.size(), 1);
      if (commits.size() > 0) begin
         got = commits.pop_front();
         chk("rs commit word", int'(got), int'({7'h06, 9'h01F}));
      end
      model_write(6, 9'h01F);
      chk_regs("rs");

      // Reset mid-transfer releases SDA at once.
      i2c_start();
      for (int i = 7; i >= 0; i--) begin
         sda_drv = 8'h34 >> i; cyc(Q);
         scl_drv = 1'b1; cyc(2 * Q);
         scl_drv = 1'b0; cyc(Q);
      end
      sda_drv = 1'b1; cyc(Q);
      chk("mid ack driven", int'(sda_oe), 1);
      rst = 1'b1; #1;
      chk("mid reset releases sda", int'(sda_oe), 0);
      cyc(2);
      scl_drv = 1'b1; cyc(Q);
      rst = 1'b0;
      cyc(Q);
      model_reset();
      chk("mid reset busy", int'(busy), 0);
      chk_regs("midrst");

      // 2-cycle SDA glitch while SCL is high.
      clear_mon();
      cyc(Q);
      sda_drv = 1'b0; cyc(2);
      sda_drv = 1'b1; cyc(3 * Q);
`ifdef I2C_RESP_FILTER_EN
      chk("glitch filtered", int'(busy_seen), 0);
`else
      chk("glitch decoded", int'(busy_seen), 1);
`endif
      chk("glitch busy end", int'(busy), 0);

      for (int t = 0; t < 16; t++) begin
         rb0 = ($urandom_range(0, 9) < 7) ? 8'h34 : 8'($urandom);
         rb1 = 8'($urandom);
         if ($urandom_range(0, 5) == 0) rb1 = {7'h0F, 1'b0};
         rb2 = 8'($urandom);
         rb3 = 8'($urandom);
         rn = $urandom_range(1, 4);
         txn($sformatf("rnd%0d", t), {rb0, rb1, rb2, rb3}, rn);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
